// File: rtl/uart_tx_buf_if.sv
// Bus bundle for the memory-mapped UART transmitter: write/read port plus the
// status and serial-line outputs. The master drives the bus, the slave answers.
interface uart_tx_buf_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] rdata_o;
  logic        full_o;
  logic        busy_o;
  logic        tx_o;

  modport master (
    output we_i, addr_i, data_i,
    input  rdata_o, full_o, busy_o, tx_o
  );

  modport slave (
    input  we_i, addr_i, data_i,
    output rdata_o, full_o, busy_o, tx_o
  );
endinterface

// File: rtl/uart_tx_buf.sv
// Memory-mapped UART transmitter. Bytes written to TXDATA are queued in a FIFO
// and sent as 8N1 frames, LSB first. STATUS reports {ovf, busy, full}; any
// write to STATUS clears the sticky overflow flag.
module uart_tx_buf #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_buf_if.slave bus
);

  localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_r, state_n;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_n;
  logic          ovf_r;
  logic [7:0]    shift_r, shift_n;
  logic [2:0]    bit_idx_r, bit_idx_n;
  logic [15:0]   baud_r, baud_n;
  logic          tx_r, tx_n;
  logic          full_r, busy_r;
  logic          hit_tx_s, hit_st_s, push_s, pop_s, baud_done_s;
  logic          unused_s;

  // Only the low byte of write data is transmitted.
  assign unused_s = ^bus.data_i[31:8];

  assign hit_tx_s    = bus.we_i && (bus.addr_i == BASE_ADDR);
  assign hit_st_s    = (bus.addr_i == (BASE_ADDR + 32'd4));
  // Full is judged on the registered count, so a same-cycle pop cannot rescue a write.
  assign push_s      = hit_tx_s && !full_r;
  assign baud_done_s = (baud_r == BAUD_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; a pop happens whenever a new frame is started.
  always_comb begin
    state_n = state_r;
    pop_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s   = 1'b1;
          state_n = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) state_n = S_DATA;
        else             state_n = S_START;
      end
      S_DATA: begin
        if (baud_done_s && (bit_idx_r == 3'd7)) state_n = S_STOP;
        else                                    state_n = S_DATA;
      end
      S_STOP: begin
        if (baud_done_s) begin
          if (count_r != CNT_ZERO) begin
            pop_s   = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_STOP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath next values: shift register, bit index, baud counter, FIFO count.
  always_comb begin
    shift_n   = shift_r;
    bit_idx_n = bit_idx_r;
    baud_n    = baud_r;
    if (pop_s) begin
      shift_n   = mem_r[rd_ptr_r];
      bit_idx_n = 3'd0;
      baud_n    = 16'd0;
    end else if (state_r == S_IDLE) begin
      baud_n = 16'd0;
    end else if (baud_done_s) begin
      baud_n = 16'd0;
      if (state_r == S_DATA) begin
        shift_n   = {1'b0, shift_r[7:1]};
        bit_idx_n = bit_idx_r + 3'd1;
      end else begin
        bit_idx_n = 3'd0;
      end
    end else begin
      baud_n = baud_r + 16'd1;
    end

    case ({push_s, pop_s})
      2'b10:   count_n = count_r + CNT_ONE;
      2'b01:   count_n = count_r - CNT_ONE;
      default: count_n = count_r;
    endcase
  end

  // Output logic: line level for the upcoming state, computed ahead so tx is registered.
  always_comb begin
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.data_i[7:0];
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else       rd_ptr_r <= rd_ptr_r;
      count_r <= count_n;
    end
  end

  // Serialiser registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      baud_r    <= 16'd0;
      tx_r      <= 1'b1;
      full_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      shift_r   <= shift_n;
      bit_idx_r <= bit_idx_n;
      baud_r    <= baud_n;
      tx_r      <= tx_n;
      full_r    <= (count_n == CNT_FULL);
      busy_r    <= (state_n != S_IDLE) || (count_n != CNT_ZERO);
    end
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (hit_tx_s && full_r) begin
      ovf_r <= 1'b1;
    end else if (bus.we_i && hit_st_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Read mux: only STATUS returns data.
  always_comb begin
    if (hit_st_s) bus.rdata_o = {29'd0, ovf_r, busy_r, full_r};
    else          bus.rdata_o = 32'd0;
  end

  assign bus.tx_o   = tx_r;
  assign bus.full_o = full_r;
  assign bus.busy_o = busy_r;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: one DUT with CLK_DIV=4/DEPTH=16 and one with
// CLK_DIV=8/DEPTH=4. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_uart_tx_buf;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] ST   = 32'h1000_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_tx_buf_if ifa();
  uart_tx_buf_if ifb();

  uart_tx_buf #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  uart_tx_buf #(.BASE_ADDR(BASE), .CLK_DIV(8), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  // Line level at frame position pos (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0)      return 1'b0;
    else if (pos == 9) return 1'b1;
    else               return b[pos-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ifa.tx_o !== 1'b1)   begin errors++; $display("FAIL rst_tx_a: got %b want 1", ifa.tx_o); end
    checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy_a: got %b want 0", ifa.busy_o); end
    checks++; if (ifa.full_o !== 1'b0) begin errors++; $display("FAIL rst_full_a: got %b want 0", ifa.full_o); end
    checks++; if (ifb.tx_o !== 1'b1)   begin errors++; $display("FAIL rst_tx_b: got %b want 1", ifb.tx_o); end
    tick();
    rst = 1'b0;
    tick(); tick();
    ifa.addr_i = ST;
    #1;
    checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", ifa.rdata_o); end
    checks++; if (ifa.tx_o !== 1'b1)     begin errors++; $display("FAIL rst_idle_tx: got %b want 1", ifa.tx_o); end
  endtask

  task automatic test_single_frame();
    logic exp;
    @(posedge clk); #1;
    ifa.we_i = 1'b1; ifa.addr_i = BASE; ifa.data_i = 32'hFFFF_FF32;
    tick();
    ifa.we_i = 1'b0; ifa.addr_i = ST;
    #1;
    checks++; if (ifa.tx_o !== 1'b1)      begin errors++; $display("FAIL single_lat_tx: got %b want 1", ifa.tx_o); end
    checks++; if (ifa.rdata_o !== 32'h2)  begin errors++; $display("FAIL single_status: got %h want 2", ifa.rdata_o); end
    for (int i = 0; i < 40; i++) begin
      tick();
      exp = frame_bit(8'h32, i / 4);
      checks++; if (ifa.tx_o !== exp) begin errors++; $display("FAIL single_bit[%0d]: got %b want %b", i, ifa.tx_o, exp); end
      if (i == 39) begin
        checks++; if (ifa.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b want 1", ifa.busy_o); end
      end
    end
    tick();
    checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", ifa.busy_o); end
    checks++; if (ifa.tx_o !== 1'b1)   begin errors++; $display("FAIL single_idle_tx: got %b want 1", ifa.tx_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b2b [10];
    logic exp;
    b2b = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h33, 8'h31, 8'h30, 8'h36, 8'h35, 8'h35};
    for (int n = 0; n <= 400; n++) begin
      if (n < 10) begin
        ifa.we_i = 1'b1; ifa.addr_i = BASE; ifa.data_i = {24'd0, b2b[n]};
      end else begin
        ifa.we_i = 1'b0; ifa.addr_i = ST;
      end
      tick();
      if (n >= 1) begin
        exp = frame_bit(b2b[(n-1) / 40], ((n-1) % 40) / 4);
        checks++; if (ifa.tx_o !== exp) begin errors++; $display("FAIL b2b_bit[%0d]: got %b want %b", n-1, ifa.tx_o, exp); end
      end
    end
    tick();
    checks++; if (ifa.busy_o !== 1'b0)   begin errors++; $display("FAIL b2b_busy_drop: got %b want 0", ifa.busy_o); end
    checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL b2b_status: got %h want 0", ifa.rdata_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] ov [6];
    logic exp;
    int   lows;
    ov = '{8'hA1, 8'h5C, 8'h0F, 8'hF0, 8'h96, 8'h3C};
    for (int n = 0; n <= 400; n++) begin
      if (n < 6) begin
        ifb.we_i = 1'b1; ifb.addr_i = BASE; ifb.data_i = {24'd0, ov[n]};
      end else if (n == 100) begin
        ifb.we_i = 1'b1; ifb.addr_i = ST; ifb.data_i = 32'h0;
      end else begin
        ifb.we_i = 1'b0; ifb.addr_i = ST;
      end
      tick();
      if (n >= 1) begin
        exp = frame_bit(ov[(n-1) / 80], ((n-1) % 80) / 8);
        checks++; if (ifb.tx_o !== exp) begin errors++; $display("FAIL ovf_bit[%0d]: got %b want %b", n-1, ifb.tx_o, exp); end
      end
      if (n == 4) begin
        checks++; if (ifb.full_o !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", ifb.full_o); end
      end
      if (n == 5) begin
        ifb.we_i = 1'b0; ifb.addr_i = ST;
        #1;
        checks++; if (ifb.rdata_o !== 32'h7) begin errors++; $display("FAIL ovf_status7: got %h want 7", ifb.rdata_o); end
      end
      if (n == 99) begin
        checks++; if (ifb.rdata_o !== 32'h6) begin errors++; $display("FAIL ovf_status6: got %h want 6", ifb.rdata_o); end
      end
      if (n == 100) begin
        checks++; if (ifb.rdata_o !== 32'h2) begin errors++; $display("FAIL ovf_clear: got %h want 2", ifb.rdata_o); end
      end
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ifb.tx_o !== 1'b1) lows++;
    end
    checks++; if (lows != 0)            begin errors++; $display("FAIL ovf_no_sixth: got %0d low cycles want 0", lows); end
    checks++; if (ifb.busy_o !== 1'b0)  begin errors++; $display("FAIL ovf_busy_drop: got %b want 0", ifb.busy_o); end
  endtask

  task automatic test_bad_addr();
    int lows;
    ifa.we_i = 1'b1; ifa.addr_i = BASE + 32'd8; ifa.data_i = 32'h55;
    tick();
    ifa.we_i = 1'b0;
    checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", ifa.busy_o); end
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.tx_o !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL bad_tx: got %0d low cycles want 0", lows); end
    ifa.addr_i = BASE; #1;
    checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL rd_txdata: got %h want 0", ifa.rdata_o); end
    ifa.addr_i = BASE + 32'd8; #1;
    checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL rd_base8: got %h want 0", ifa.rdata_o); end
    ifa.addr_i = 32'h0; #1;
    checks++; if (ifa.rdata_o !== 32'h0) begin errors++; $display("FAIL rd_zero: got %h want 0", ifa.rdata_o); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    @(posedge clk); #1;
    ifa.we_i = 1'b1; ifa.addr_i = BASE; ifa.data_i = 32'h32;
    tick();
    ifa.data_i = 32'h55;
    tick();
    ifa.we_i = 1'b0; ifa.addr_i = ST;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (ifa.tx_o !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", ifa.tx_o); end
    rst = 1'b1;
    #1;
    checks++; if (ifa.tx_o !== 1'b1)   begin errors++; $display("FAIL mid_rst_tx: got %b want 1", ifa.tx_o); end
    checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", ifa.busy_o); end
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((ifa.tx_o !== 1'b1) || (ifa.busy_o !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_frames: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    ifa.we_i = 1'b0; ifa.addr_i = 32'h0; ifa.data_i = 32'h0;
    ifb.we_i = 1'b0; ifb.addr_i = 32'h0; ifb.data_i = 32'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_bad_addr();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
